// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    localparam int unsigned DefaultWidth = 16;
    localparam int unsigned DefaultCntW  = $clog2(DefaultWidth);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    // A one-bit datapath would otherwise get a zero-width counter.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor_1b.sv
// Combinational one-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor_1b (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor_16b.sv
// Bit-serial unsigned subtractor: one bit of a - b per clock behind a start/done handshake.
module serial_subtractor_16b
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;

    logic             fs_d;
    logic             fs_bout;
    logic [WIDTH-1:0] part_shift;
    logic             load;

    full_subtractor_1b u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // LSB-first processing: each new difference bit enters at the MSB, so after
    // WIDTH shifts bit 0 has reached position 0.
    assign part_shift = {fs_d, part_q[WIDTH-1:1]};

    // Start is accepted in IDLE and DONE; it is ignored while shifting.
    assign load = start && (state_q != StShift);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        part_d   = part_q;
        br_d     = br_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        unique case (state_q)
            StIdle: begin
                state_d = StIdle;
            end
            StShift: begin
                part_d = part_shift;
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                br_d   = fs_bout;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    cnt_d    = '0;
                    diff_d   = part_shift;
                    borrow_d = fs_bout;
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load) begin
            state_d = StShift;
            a_d     = a;
            b_d     = b;
            part_d  = '0;
            br_d    = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            part_q   <= '0;
            br_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            part_q   <= part_d;
            br_q     <= br_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy   = (state_q == StShift);
    assign done   = (state_q == StDone);
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: doc/serial_subtractor_16b.md
# serial_subtractor_16b

Bit-serial 16-bit unsigned subtractor that computes a − b one bit per clock and returns the 16-bit difference and a borrow flag. It is the inverse companion to the team's combinational `fulladder_16b`. It shares that block's operand width and random-vector bench style, but trades area for latency behind a start/done handshake. It sits beside the adder in the datapath experiments, and its results can be cross-checked against it: a − b + b must recover a.

## Interface
Parameters:
- `WIDTH`, default 16, operand and result width in bits.

Ports:
- `clk`  input  1  single system clock, rising-edge active.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request a subtraction; sampled on the rising edge while `busy` = 0.
- `a`  input  WIDTH  minuend, captured on the accepting edge.
- `b`  input  WIDTH  subtrahend, captured on the accepting edge.
- `busy`  output  1  high while bits are being processed.
- `done`  output  1  one-cycle pulse when a result completes.
- `diff`  output  WIDTH  a − b modulo 2^WIDTH, held until the next completion.
- `borrow`  output  1  1 iff a < b (unsigned), held with `diff`.

## Operation
- States:
  - IDLE: `busy` = 0, `done` = 0.
  - SHIFT: `busy` = 1.
  - DONE: `done` = 1, `busy` = 0.
- IDLE → SHIFT on `start` = 1.
  - Load the `a` and `b` shift registers.
  - Clear the internal borrow bit and clear the partial-difference register.
  - Set the bit counter to 0.
- SHIFT, each edge:
  - Take LSBs a0, b0 and the internal borrow br.
  - Compute d = a0 ^ b0 ^ br.
  - Compute br' = (~a0 & b0) | (~(a0 ^ b0) & br).
  - Shift d into the MSB of the partial-difference register and shift `a` and `b` right by one.
  - Increment the counter.
- SHIFT → DONE on the edge that processes counter value WIDTH−1.
  - On that same edge, `diff` and `borrow` are loaded from the final partial register and the final br'.
- DONE → SHIFT if `start` = 1, with a new load as above; otherwise DONE → IDLE.
- `start` while in SHIFT is ignored; operand inputs are don't-care while `busy` = 1.
- `diff` and `borrow` change only on the completing edge or on reset. They are never partial values.
- Arithmetic is modulo 2^WIDTH with no sign interpretation. `borrow` equals the inverse of the carry-out of a + ~b + 1.

## Timing
- Reset values (asynchronous on `rst_n` = 0):
  - State = IDLE, counter = 0, internal borrow = 0.
  - `busy` = 0, `done` = 0, `diff` = 0, `borrow` = 0.
- Call the edge that samples `start` = 1 edge 0.
  - `busy` rises after edge 0.
  - Bits 0..WIDTH−1 are processed on edges 1..WIDTH.
  - After edge WIDTH: `busy` = 0, `done` = 1, and `diff`/`borrow` are valid.
  - `done` falls after edge WIDTH+1 unless a new job completes.
- Latency is WIDTH edges from start-sample to result. Throughput is one result per WIDTH+1 cycles when `start` is held high, because start is accepted in DONE.
- Reset mid-operation aborts the job immediately. No `done` pulse is produced, and outputs return to reset values.
- Exactly one `done` pulse per accepted start.

## Structure
- Package `serial_arith_pkg`:
  - State enum (IDLE, SHIFT, DONE).
  - `WIDTH` default constant.
  - Counter width `$clog2(WIDTH)`.
- Sub-module `full_subtractor_1b`: combinational; inputs a, b, bin; outputs d, bout. Instantiated once in the SHIFT datapath.
- Top level holds the FSM, counter, operand shift registers, partial-difference register and result registers.

## Test plan
- a=0x0005, b=0x0003, start pulse → after 16 edges `done`=1, `diff`=0x0002, `borrow`=0; `busy` high for exactly 16 cycles.
- a=0x0003, b=0x0005 → `diff`=0xFFFE, `borrow`=1. Then a=0x0000, b=0x0001 → `diff`=0xFFFF, `borrow`=1.
- a=0xFFFF, b=0xFFFF → `diff`=0x0000, `borrow`=0. Then a=0x8000, b=0x0001 → `diff`=0x7FFF, `borrow`=0.
- Start job a=0x1234, b=0x0034.
  - Pulse `start` with a=0xFFFF, b=0x0001 at cycle 5 of busy → ignored.
  - Result `diff`=0x1200.
  - Exactly one `done` pulse.
- Drop `rst_n` at cycle 8 of a job:
  - All outputs go to 0 asynchronously and no `done` appears.
  - After release, a new job a=0x0010, b=0x0001 gives `diff`=0x000F.
- Hold `start` high with 10 random operand pairs applied at each DONE cycle:
  - Each result is compared against a−b and a<b computed by the model.
  - `done` spacing is 17 cycles.
  - `diff` + b (via `fulladder_16b`) equals a.
